// File: rtl/l2_types.sv
// l2_types: shared word/line types, offset width and controller states for the L2 cache
package l2_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [127:0] lc3b_8words;
  localparam int L2_OFF_W = 4;
  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} l2_state_t;
endpackage

// File: rtl/l2_plru_tree.sv
// l2_plru_tree: combinational tree pseudo-LRU update and victim walk for one set
module l2_plru_tree #(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         i_bits,
  input  logic [$clog2(WAYS)-1:0] i_way,
  input  logic                    i_valid,
  output logic [WAYS-2:0]         o_bits,
  output logic [$clog2(WAYS)-1:0] o_victim
);
  localparam int LW = $clog2(WAYS);
  logic [WAYS-1:0] w_cur, w_nxt;
  logic [LW:0]     w_an, w_vn;
  logic [LW-1:0]   w_ai, w_vi;
  assign w_cur  = {1'b0, i_bits};
  assign o_bits = w_nxt[WAYS-2:0];
  // walk from the root along the accessed way; each node points to the other subtree
  always_comb begin
    w_nxt = w_cur;
    w_an  = (LW+1)'(1);
    w_ai  = '0;
    for (int l = LW - 1; l >= 0; l--) begin
      w_ai = LW'(w_an - 1'b1);
      if (i_valid) w_nxt[w_ai] = i_way[l];
      w_an = {w_an[LW-1:0], i_way[l]};
    end
  end
  // follow node bits from the root: 0 steps to the upper half, so all-zero picks the last way
  always_comb begin
    w_vn     = (LW+1)'(1);
    w_vi     = '0;
    o_victim = '0;
    for (int l = LW - 1; l >= 0; l--) begin
      w_vi        = LW'(w_vn - 1'b1);
      o_victim[l] = ~w_cur[w_vi];
      w_vn        = {w_vn[LW-1:0], ~w_cur[w_vi]};
    end
  end
endmodule

// File: rtl/l2cache_nway.sv
// l2cache_nway: write-back, write-allocate set-associative L2 cache with tree PLRU and controller FSM
module l2cache_nway
  import l2_types::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_stb,
  input  logic         cpu_we,
  input  logic [15:0]  adr_i_cpu,
  input  logic [15:0]  cpu_sel,
  input  logic [127:0] dat_i_cpu,
  output logic [127:0] dat_o_cpu,
  output logic         cpu_ack,
  output logic         mem_stb,
  output logic         mem_we,
  output logic [15:0]  adr_o_mem,
  output logic [127:0] dat_o_mem,
  input  logic [127:0] dat_i_mem,
  input  logic         mem_ack
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 16 - L2_OFF_W - IDX_W;
  localparam int WW    = $clog2(WAYS);
  l2_state_t                 r_state;
  lc3b_word                  r_adr;
  logic                      r_we;
  logic [15:0]               r_sel;
  lc3b_8words                r_dat;
  logic [WW-1:0]             r_victim;
  logic [TAG_W-1:0]          r_tag  [WAYS][SETS];
  lc3b_8words                r_data [WAYS][SETS];
  logic [SETS-1:0][WAYS-1:0] r_valid, r_dirty;
  logic [SETS-1:0][WAYS-2:0] r_plru;
  logic                      r_mem_stb, r_mem_we;
  lc3b_word                  r_mem_adr;
  lc3b_8words                r_mem_dat;
  logic [IDX_W-1:0]          w_idx;
  logic [TAG_W-1:0]          w_tag;
  logic [WAYS-1:0]           w_hit_vec;
  logic                      w_hit, w_any_inv, w_touch, w_vict_dirty;
  logic [WW-1:0]             w_hit_way, w_inv_way, w_plru_vic, w_vict;
  lc3b_8words                w_hit_line, w_wr_line;
  logic [WAYS-2:0]           w_plru_nxt;
  logic                      w_unused;
  assign w_idx        = r_adr[IDX_W+L2_OFF_W-1:L2_OFF_W];
  assign w_tag        = r_adr[15:IDX_W+L2_OFF_W];
  assign w_unused     = ^r_adr[L2_OFF_W-1:0];
  assign w_hit        = |w_hit_vec;
  assign w_hit_line   = r_data[w_hit_way][w_idx];
  assign w_vict       = w_any_inv ? w_inv_way : w_plru_vic;
  assign w_vict_dirty = r_valid[w_idx][w_vict] & r_dirty[w_idx][w_vict];
  assign w_touch      = (r_state == COMPARE && w_hit) || (r_state == ALLOCATE && mem_ack);
  assign cpu_ack      = r_state == COMPARE && w_hit;
  assign dat_o_cpu    = cpu_ack ? w_hit_line : '0;
  assign mem_stb      = r_mem_stb;
  assign mem_we       = r_mem_we;
  assign adr_o_mem    = r_mem_adr;
  assign dat_o_mem    = r_mem_dat;
  l2_plru_tree #(.WAYS(WAYS)) u_plru (
    .i_bits   (r_plru[w_idx]),
    .i_way    (r_state == ALLOCATE ? r_victim : w_hit_way),
    .i_valid  (w_touch),
    .o_bits   (w_plru_nxt),
    .o_victim (w_plru_vic)
  );
  // tag match per way, plus the lowest-index invalid way (scanned downward so the lowest wins)
  always_comb begin
    w_hit_vec = '0;
    w_hit_way = '0;
    w_inv_way = '0;
    w_any_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      w_hit_vec[w] = r_valid[w_idx][w] && r_tag[w][w_idx] == w_tag;
      if (w_hit_vec[w]) w_hit_way = WW'(w);
      if (!r_valid[w_idx][w]) begin
        w_inv_way = WW'(w);
        w_any_inv = 1'b1;
      end
    end
  end
  // byte-enable merge of the request data into the hit line
  always_comb begin
    w_wr_line = w_hit_line;
    for (int i = 0; i < 16; i++) w_wr_line[8*i +: 8] = r_sel[i] ? r_dat[8*i +: 8] : w_hit_line[8*i +: 8];
  end
  // controller FSM, request latch, array updates and registered memory-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_valid   <= '0;
      r_dirty   <= '0;
      r_plru    <= '0;
      r_mem_stb <= 1'b0;
      r_mem_we  <= 1'b0;
      r_mem_adr <= '0;
      r_mem_dat <= '0;
    end else begin
      if (w_touch) r_plru[w_idx] <= w_plru_nxt;
      case (r_state)
        IDLE: if (cpu_stb) begin
          r_adr   <= adr_i_cpu;
          r_we    <= cpu_we;
          r_sel   <= cpu_sel;
          r_dat   <= dat_i_cpu;
          r_state <= COMPARE;
        end
        COMPARE: if (w_hit) begin
          if (r_we) begin
            r_data[w_hit_way][w_idx]  <= w_wr_line;
            r_dirty[w_idx][w_hit_way] <= 1'b1;
          end
          r_state <= IDLE;
        end else begin
          r_victim  <= w_vict;
          r_mem_stb <= 1'b1;
          r_mem_we  <= w_vict_dirty;
          r_mem_adr <= w_vict_dirty ? {r_tag[w_vict][w_idx], w_idx, {L2_OFF_W{1'b0}}} : {w_tag, w_idx, {L2_OFF_W{1'b0}}};
          r_mem_dat <= w_vict_dirty ? r_data[w_vict][w_idx] : '0;
          r_state   <= w_vict_dirty ? WRITEBACK : ALLOCATE;
        end
        WRITEBACK: if (mem_ack) begin
          r_mem_we  <= 1'b0;
          r_mem_adr <= {w_tag, w_idx, {L2_OFF_W{1'b0}}};
          r_mem_dat <= '0;
          r_state   <= ALLOCATE;
        end
        ALLOCATE: if (mem_ack) begin
          r_data[r_victim][w_idx]  <= dat_i_mem;
          r_tag[r_victim][w_idx]   <= w_tag;
          r_valid[w_idx][r_victim] <= 1'b1;
          r_dirty[w_idx][r_victim] <= 1'b0;
          r_mem_stb                <= 1'b0;
          r_mem_adr                <= '0;
          r_state                  <= COMPARE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2cache_nway.sv
// tb_l2cache_nway: directed and random accesses checked against a behavioural cache/memory model
module tb_l2cache_nway;
  localparam int WAYS = 4;
  localparam int SETS = 16;
  localparam int TW   = 8;
  logic         clk = 1'b0, reset = 1'b1, cpu_stb = 1'b0, cpu_we = 1'b0, mem_ack = 1'b0;
  logic [15:0]  adr_i_cpu = '0, cpu_sel = '0;
  logic [127:0] dat_i_cpu = '0, dat_i_mem = '0;
  logic [127:0] dat_o_cpu, dat_o_mem;
  logic [15:0]  adr_o_mem;
  logic         cpu_ack, mem_stb, mem_we;
  logic         valid_m [SETS][WAYS];
  logic         dirty_m [SETS][WAYS];
  logic [TW-1:0] tag_m  [SETS][WAYS];
  logic [127:0] data_m  [SETS][WAYS];
  bit           pl_m    [SETS][WAYS];
  logic [127:0] mem_m [logic [15:0]];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  l2cache_nway #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .reset(reset), .cpu_stb(cpu_stb), .cpu_we(cpu_we), .adr_i_cpu(adr_i_cpu),
    .cpu_sel(cpu_sel), .dat_i_cpu(dat_i_cpu), .dat_o_cpu(dat_o_cpu), .cpu_ack(cpu_ack),
    .mem_stb(mem_stb), .mem_we(mem_we), .adr_o_mem(adr_o_mem), .dat_o_mem(dat_o_mem),
    .dat_i_mem(dat_i_mem), .mem_ack(mem_ack)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic void clear_model();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        valid_m[s][w] = 1'b0;
        dirty_m[s][w] = 1'b0;
        pl_m[s][w]    = 1'b0;
      end
  endfunction
  function automatic logic [127:0] rd_mem(input logic [15:0] a);
    return mem_m.exists(a) ? mem_m[a] : {4{a, ~a}};
  endfunction
  function automatic int victim_m(input int s);
    int n;
    for (int w = 0; w < WAYS; w++) if (!valid_m[s][w]) return w;
    n = 1;
    while (n < WAYS) n = 2 * n + (pl_m[s][n] ? 0 : 1);
    return n - WAYS;
  endfunction
  function automatic void touch_m(input int s, input int w);
    int n;
    n = WAYS + w;
    while (n > 1) begin
      pl_m[s][n/2] = (n % 2) == 1;
      n = n / 2;
    end
  endfunction
  task automatic access(input logic we, input logic [15:0] a, input logic [15:0] sel, input logic [127:0] d, input bit abort);
    int s, hw, vw, dw, df, exp_lat, exp_mem, nmem, cnt;
    logic [TW-1:0] t;
    bit hit, wb, inflight, done, aborted;
    logic [15:0] wba, fa;
    logic [127:0] wbd, line;
    s = int'(a[7:4]);
    t = a[15:8];
    hw = -1;
    for (int w = 0; w < WAYS; w++) if (valid_m[s][w] && tag_m[s][w] == t) hw = w;
    hit = hw >= 0;
    vw = hit ? hw : victim_m(s);
    wb = !hit && valid_m[s][vw] && dirty_m[s][vw];
    wba = {tag_m[s][vw], a[7:4], 4'h0};
    wbd = data_m[s][vw];
    fa = {a[15:4], 4'h0};
    if (hit) line = data_m[s][hw];
    else line = rd_mem(fa);
    dw = $urandom_range(0, 3);
    df = $urandom_range(0, 3);
    exp_lat = hit ? 1 : wb ? 4 + dw + df : 3 + df;
    exp_mem = hit ? 0 : wb ? 2 : 1;
    nmem = 0; cnt = 0; inflight = 0; done = 0; aborted = 0;
    @(negedge clk);
    cpu_stb = 1'b1; cpu_we = we; adr_i_cpu = a; cpu_sel = sel; dat_i_cpu = d;
    mem_ack = 1'($urandom_range(0, 1));
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_stb && !inflight) begin
        nmem++;
        inflight = 1;
        if (nmem == 1 && wb) begin
          chk("wb_we", mem_we, 1);
          chk("wb_adr", adr_o_mem, wba);
          chk("wb_dat", dat_o_mem, wbd);
          cnt = dw;
          if (abort) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            cpu_stb = 1'b0;
            chk("abort_mem_stb", mem_stb, 0);
            chk("abort_ack", cpu_ack, 0);
            clear_model();
            aborted = 1;
            done = 1;
          end
        end else begin
          chk("fill_we", mem_we, 0);
          chk("fill_adr", adr_o_mem, fa);
          cnt = df;
        end
      end
      if (!done && inflight) begin
        if (cnt == 0) begin
          mem_ack = 1'b1;
          dat_i_mem = line;
          inflight = 0;
        end else cnt--;
      end
      if (!done && cpu_ack) begin
        chk("latency", c, exp_lat);
        chk("mem_txns", nmem, exp_mem);
        if (!we) chk("rd_data", dat_o_cpu, line);
        cpu_stb = 1'b0;
        done = 1;
      end
    end
    chk("completed", done, 1);
    if (!aborted) begin
      if (!hit) begin
        if (wb) mem_m[wba] = wbd;
        valid_m[s][vw] = 1'b1;
        dirty_m[s][vw] = 1'b0;
        tag_m[s][vw]   = t;
        data_m[s][vw]  = line;
        touch_m(s, vw);
      end
      if (we) begin
        for (int i = 0; i < 16; i++) if (sel[i]) data_m[s][vw][8*i +: 8] = d[8*i +: 8];
        dirty_m[s][vw] = 1'b1;
      end
      touch_m(s, vw);
    end
  endtask
  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    clear_model();
    repeat (3) @(negedge clk);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_mem_stb", mem_stb, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_adr_o_mem", adr_o_mem, 0);
    chk("rst_dat_o_cpu", dat_o_cpu, 0);
    chk("rst_dat_o_mem", dat_o_mem, 0);
    reset = 1'b0;
    access(0, 16'h1230, 16'h0, '0, 0);
    access(0, 16'h1230, 16'h0, '0, 0);
    access(1, 16'h1230, 16'h0003, {112'h0, 16'hBEEF}, 0);
    access(0, 16'h1230, 16'h0, '0, 0);
    for (int t = 8'h10; t <= 8'h13; t++) access(0, {8'(t), 8'h50}, 16'h0, '0, 0);
    for (int t = 8'h11; t <= 8'h13; t++) access(0, {8'(t), 8'h50}, 16'h0, '0, 0);
    access(0, 16'h1450, 16'h0, '0, 0);
    access(0, 16'h1150, 16'h0, '0, 0);
    access(0, 16'h1350, 16'h0, '0, 0);
    access(0, 16'h1050, 16'h0, '0, 0);
    access(1, 16'h2030, 16'hFFFF, rnd_line(), 0);
    access(1, 16'h3030, 16'hFFFF, rnd_line(), 0);
    access(1, 16'h4030, 16'hFFFF, rnd_line(), 0);
    access(1, 16'h5030, 16'h00F0, rnd_line(), 0);
    access(0, 16'h5030, 16'h0, '0, 0);
    access(0, 16'h1230, 16'h0, '0, 0);
    access(1, 16'h6030, 16'hFFFF, rnd_line(), 1);
    access(0, 16'h1230, 16'h0, '0, 0);
    access(0, 16'h5030, 16'h0, '0, 0);
    for (int k = 0; k < 250; k++)
      access(1'($urandom_range(0, 1)), {8'($urandom_range(0, 6)), 4'($urandom_range(0, 2)), 4'($urandom)},
             16'($urandom), rnd_line(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
